act_sram_arb: RTL and testbench
===============================

ACT_SRAM_ARB -- requirements
Module: act_sram_arb

Interface
- REQ-001 The block SHALL have parameter DEPTH, default 50176, meaning the number of activation SRAM words.
- REQ-002 The block SHALL have parameter PLANE, default 784, meaning the address stride between broadcast planes (28*28).
- REQ-003 The block SHALL have parameter DATA_W, default 48, meaning the SRAM word width (4 lanes x 12b).
- REQ-004 The block SHALL have these ports, listed as name, direction, width, meaning:
  - clk  in  1  single clock.
  - rst  in  1  synchronous reset, active-high.
  - l_req  in  1  loader write request.
  - l_gnt  out  1  loader write granted this cycle.
  - l_addr  in  16  loader write address.
  - l_data  in  48  loader write data.
  - l_mask  in  4  loader lane mask; 1 keeps the old lane.
  - l_bcast  in  1  loader broadcast-write mode.
  - e_wreq  in  1  engine write request.
  - e_wgnt  out  1  engine write granted.
  - e_waddr  in  16  engine write address.
  - e_wdata  in  48  engine write data.
  - e_wmask  in  4  engine lane mask.
  - e_rreq  in  1  engine read request; always accepted.
  - e_raddr  in  16  engine read address.
  - e_rvalid  out  1  engine read data valid.
  - e_rdata  out  48  engine read data.
  - sram_csb  out  1  SRAM chip select, active-low.
  - sram_wsb  out  1  SRAM write enable, active-low.
  - sram_msb  out  1  SRAM mode; 1 = masked, 0 = broadcast.
  - sram_wordmask  out  4  SRAM lane mask.
  - sram_waddr  out  16  SRAM write address.
  - sram_raddr  out  16  SRAM read address.
  - sram_wdata  out  48  SRAM write data.
  - sram_rdata  in  48  SRAM read data, registered inside the SRAM.
  - err_addr  out  1  sticky out-of-range flag.
  - err_clr  in  1  clears err_addr.

Function
- REQ-005 The write grant SHALL be combinational within the request cycle T; a transfer occurs when req and gnt are both high.
- REQ-006 At most one write SHALL be granted per cycle.
- REQ-007 Write arbitration SHALL be round-robin with a priority pointer:
  - pointer = L after reset;
  - when both l_req and e_wreq are high, the non-pointer requester wins next time;
  - a lone requester is granted immediately and the pointer is unchanged.
- REQ-008 The command SHALL be registered onto the sram_* outputs in cycle T+1.
  - sram_csb=0 when a write or read is issued; otherwise 1.
  - sram_wsb=0 only for a granted, in-range write.
- REQ-009 A read and a write MAY issue in the same T+1 cycle.
- REQ-010 sram_raddr SHALL hold its last value when no read is issued.
- REQ-011 Engine writes SHALL always use sram_msb=1.
- REQ-012 Loader writes SHALL use sram_msb equal to the inverse of l_bcast.
- REQ-013 Read latency: e_rvalid SHALL pulse in cycle T+2 for each e_rreq in T, with e_rdata = sram_rdata.
- REQ-014 Back-to-back reads SHALL sustain 1 per cycle.
- REQ-015 Range checks:
  - a masked write or read is out of range when addr >= DEPTH;
  - a broadcast write is out of range when addr + 3*PLANE >= DEPTH (addr > 47823 at default).
- REQ-016 An out-of-range write SHALL still be granted and SHALL then be dropped: sram_wsb=1, err_addr set.
- REQ-017 An out-of-range read SHALL still produce e_rvalid, with e_rdata=0 and err_addr set.
- REQ-018 err_addr SHALL be sticky until err_clr. Set SHALL win over a same-cycle err_clr.
- REQ-019 Outputs with no transaction:
  - l_gnt, e_wgnt and e_rvalid SHALL be low;
  - sram_wdata, sram_waddr and sram_wordmask SHALL hold their values.

Reset
- REQ-020 On rst high at an edge, the outputs SHALL take these values:
  - sram_csb=1, sram_wsb=1, sram_msb=1;
  - sram_wordmask=4'hF; sram_waddr, sram_raddr and sram_wdata = 0;
  - e_rvalid=0, e_rdata=0, err_addr=0; pointer=L.
- REQ-021 While rst is high, l_gnt and e_wgnt SHALL be 0.
- REQ-022 Commands in flight at reset SHALL be discarded; no e_rvalid SHALL appear for reads accepted before reset.

Configuration
- REQ-023 Macro ACT_SRAM_ARB_RAW_BYPASS_EN, when defined, SHALL enable write-to-read forwarding.
  - It applies when a masked write (msb=1) and a read target the same address in the same command cycle.
  - e_rdata SHALL then equal the new data merged per lane: lanes with mask 0 take the written data, lanes with mask 1 take the old SRAM data.
- REQ-024 Without ACT_SRAM_ARB_RAW_BYPASS_EN, e_rdata SHALL return the pre-write data.
- REQ-025 Broadcast writes SHALL never be forwarded.

Verification
- REQ-026 l_req and e_wreq held high for 4 cycles -> grants L,E,L,E; sram_wsb=0 in each of the following 4 cycles.
- REQ-027 e_rreq with raddr 0..3 on consecutive cycles, SRAM preloaded with mem[i]=i -> e_rvalid for 4 cycles starting at T+2, e_rdata=0,1,2,3.
- REQ-028 Loader broadcast write addr=47824 -> l_gnt=1, sram_wsb stays 1, err_addr=1. Then err_clr -> err_addr=0.
- REQ-029 Loader broadcast write addr=10, data=48'h001_002_003_004, mask=0 -> sram_msb=0. Afterwards reads of 10, 794, 1578 and 2362 return lanes replicated with 001, 002, 003 and 004.
- REQ-030 Engine write addr 5, data 48'hAAA_BBB_CCC_DDD, mask 4'b0011, old word 0, with a read of 5 in the same cycle:
  - with ACT_SRAM_ARB_RAW_BYPASS_EN -> e_rdata=48'hAAA_BBB_000_000;
  - without it -> e_rdata=0.
- REQ-031 rst asserted in the cycle after a read grant -> no e_rvalid; sram_csb=1 and all outputs at reset values.

Source files
------------

// File: rtl/act_sram_arb_if.sv
// Bus bundle for the activation SRAM arbiter: loader write port, engine
// write/read ports, SRAM command/data port and the error flag.
// Handshake: a write transfers in the cycle where req and gnt are both high
// (gnt is combinational on req). Reads have no back-pressure: every e_rreq
// cycle is accepted and answered by exactly one e_rvalid pulse two cycles later.
// arb_ptr exposes the arbiter priority pointer (0 = loader, 1 = engine).
interface act_sram_arb_if #(
    parameter int DATA_W = 48
);
    logic              l_req;
    logic              l_gnt;
    logic [15:0]       l_addr;
    logic [DATA_W-1:0] l_data;
    logic [3:0]        l_mask;
    logic              l_bcast;

    logic              e_wreq;
    logic              e_wgnt;
    logic [15:0]       e_waddr;
    logic [DATA_W-1:0] e_wdata;
    logic [3:0]        e_wmask;
    logic              e_rreq;
    logic [15:0]       e_raddr;
    logic              e_rvalid;
    logic [DATA_W-1:0] e_rdata;

    logic              sram_csb;
    logic              sram_wsb;
    logic              sram_msb;
    logic [3:0]        sram_wordmask;
    logic [15:0]       sram_waddr;
    logic [15:0]       sram_raddr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    logic              err_addr;
    logic              err_clr;
    logic              arb_ptr;

    modport slave (
        input  l_req, l_addr, l_data, l_mask, l_bcast,
        input  e_wreq, e_waddr, e_wdata, e_wmask, e_rreq, e_raddr,
        input  sram_rdata, err_clr,
        output l_gnt, e_wgnt, e_rvalid, e_rdata,
        output sram_csb, sram_wsb, sram_msb, sram_wordmask,
        output sram_waddr, sram_raddr, sram_wdata,
        output err_addr, arb_ptr
    );

    modport master (
        output l_req, l_addr, l_data, l_mask, l_bcast,
        output e_wreq, e_waddr, e_wdata, e_wmask, e_rreq, e_raddr,
        output sram_rdata, err_clr,
        input  l_gnt, e_wgnt, e_rvalid, e_rdata,
        input  sram_csb, sram_wsb, sram_msb, sram_wordmask,
        input  sram_waddr, sram_raddr, sram_wdata,
        input  err_addr, arb_ptr
    );
endinterface

// File: rtl/act_sram_arb.sv
// Activation SRAM arbiter. Round-robin write arbitration between the loader
// and the engine, a free-running read path, registered SRAM commands, address
// range checking with a sticky error flag.
// Optional feature macro: ACT_SRAM_ARB_RAW_BYPASS_EN forwards masked write
// data to a same-address read issued in the same command cycle.
module act_sram_arb #(
    parameter int DEPTH  = 50176,
    parameter int PLANE  = 784,
    parameter int DATA_W = 48
) (
    input logic           clk,
    input logic           rst,
    act_sram_arb_if.slave bus
);
    localparam int LANES  = 4;
    localparam int LANE_W = DATA_W / LANES;

    typedef enum logic {
        PTR_L = 1'b0,
        PTR_E = 1'b1
    } ptr_t;

    // Out-of-range test; a broadcast write touches four planes, so its last
    // plane must also fit.
    function automatic logic addr_oor(input logic [15:0] a, input logic bcast);
        logic [31:0] a32;
        a32 = {16'd0, a};
        if (bcast) begin
            return (a32 + 32'(3 * PLANE)) >= 32'(DEPTH);
        end
        return a32 >= 32'(DEPTH);
    endfunction

    ptr_t              ptr_q;
    ptr_t              ptr_d;
    logic              l_gnt;
    logic              e_wgnt;

    logic              wr_any;
    logic [15:0]       wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [3:0]        wr_mask;
    logic              wr_bcast;
    logic              wr_oor;
    logic              wr_ok;
    logic              rd_oor;
    logic              rd_ok;
    logic              err_set;

    logic              csb_q;
    logic              wsb_q;
    logic              msb_q;
    logic [3:0]        mask_q;
    logic [15:0]       waddr_q;
    logic [15:0]       raddr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              s1_valid;
    logic              s1_oor;
    logic              rvalid_q;
    logic              s2_oor;
    logic              err_q;
    logic [DATA_W-1:0] rdata_mux;

    // Priority pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= PTR_L;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Grant decode: contention goes to the pointer owner and hands priority
    // to the other side; a lone requester leaves the pointer alone.
    always_comb begin
        ptr_d  = ptr_q;
        l_gnt  = 1'b0;
        e_wgnt = 1'b0;
        if (!rst) begin
            if (bus.l_req && bus.e_wreq) begin
                if (ptr_q == PTR_L) begin
                    l_gnt = 1'b1;
                    ptr_d = PTR_E;
                end else begin
                    e_wgnt = 1'b1;
                    ptr_d  = PTR_L;
                end
            end else begin
                l_gnt  = bus.l_req;
                e_wgnt = bus.e_wreq;
            end
        end
    end

    // Winning write command and range checks for both ports.
    always_comb begin
        wr_any   = l_gnt | e_wgnt;
        wr_addr  = l_gnt ? bus.l_addr : bus.e_waddr;
        wr_data  = l_gnt ? bus.l_data : bus.e_wdata;
        wr_mask  = l_gnt ? bus.l_mask : bus.e_wmask;
        wr_bcast = l_gnt & bus.l_bcast;
        wr_oor   = addr_oor(wr_addr, wr_bcast);
        wr_ok    = wr_any & ~wr_oor;
        rd_oor   = addr_oor(bus.e_raddr, 1'b0);
        rd_ok    = bus.e_rreq & ~rd_oor;
        err_set  = (wr_any & wr_oor) | (bus.e_rreq & rd_oor);
    end

    // SRAM command register; write/read fields hold when not refreshed.
    always_ff @(posedge clk) begin
        if (rst) begin
            csb_q   <= 1'b1;
            wsb_q   <= 1'b1;
            msb_q   <= 1'b1;
            mask_q  <= 4'hF;
            waddr_q <= '0;
            raddr_q <= '0;
            wdata_q <= '0;
        end else begin
            csb_q <= ~(wr_ok | rd_ok);
            wsb_q <= ~wr_ok;
            if (wr_ok) begin
                msb_q   <= ~wr_bcast;
                mask_q  <= wr_mask;
                waddr_q <= wr_addr;
                wdata_q <= wr_data;
            end
            if (rd_ok) begin
                raddr_q <= bus.e_raddr;
            end
        end
    end

    // Read tracking pipeline; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_oor   <= 1'b0;
            rvalid_q <= 1'b0;
            s2_oor   <= 1'b0;
        end else begin
            s1_valid <= bus.e_rreq;
            s1_oor   <= rd_oor;
            rvalid_q <= s1_valid;
            s2_oor   <= s1_oor;
        end
    end

    // Sticky error flag; a new error beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end else if (bus.err_clr) begin
            err_q <= 1'b0;
        end
    end

`ifdef ACT_SRAM_ARB_RAW_BYPASS_EN
    logic              fwd_hit;
    logic              fwd_q;
    logic [DATA_W-1:0] fwd_data_q;
    logic [3:0]        fwd_mask_q;

    // A masked write and an in-range read to the same word in one command
    // cycle; the SRAM returns pre-write data, so the new lanes are patched in.
    assign fwd_hit = s1_valid & ~s1_oor & ~wsb_q & msb_q & (raddr_q == waddr_q);

    // Capture the write being forwarded alongside the SRAM read.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
            fwd_mask_q <= 4'hF;
        end else begin
            fwd_q      <= fwd_hit;
            fwd_data_q <= wdata_q;
            fwd_mask_q <= mask_q;
        end
    end

    // Lane merge: mask 0 lanes take the written data, mask 1 lanes the old data.
    always_comb begin
        rdata_mux = bus.sram_rdata;
        if (fwd_q) begin
            for (int i = 0; i < LANES; i++) begin
                if (!fwd_mask_q[i]) begin
                    rdata_mux[i*LANE_W +: LANE_W] = fwd_data_q[i*LANE_W +: LANE_W];
                end
            end
        end
    end
`else
    assign rdata_mux = bus.sram_rdata;
`endif

    assign bus.l_gnt         = l_gnt;
    assign bus.e_wgnt        = e_wgnt;
    assign bus.sram_csb      = csb_q;
    assign bus.sram_wsb      = wsb_q;
    assign bus.sram_msb      = msb_q;
    assign bus.sram_wordmask = mask_q;
    assign bus.sram_waddr    = waddr_q;
    assign bus.sram_raddr    = raddr_q;
    assign bus.sram_wdata    = wdata_q;
    assign bus.e_rvalid      = rvalid_q;
    // Out-of-range reads and idle cycles return zero.
    assign bus.e_rdata       = (rvalid_q && !s2_oor) ? rdata_mux : '0;
    assign bus.err_addr      = err_q;
    assign bus.arb_ptr       = ptr_q;

endmodule

// File: tb/tb_act_sram_arb.sv
// Bench for act_sram_arb: behavioural SRAM, directed stimulus, read scoreboard.
module tb_act_sram_arb;
    localparam int DEPTH  = 50176;
    localparam int PLANE  = 784;
    localparam int DATA_W = 48;
    localparam int LANE_W = DATA_W / 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    logic [DATA_W-1:0] exp_q[$];
    int                exp_cyc_q[$];
    logic [DATA_W-1:0] mem[0:DEPTH-1];
    logic [DATA_W-1:0] mon_exp;
    int                mon_cyc;
    logic [DATA_W-1:0] fwd_exp;

    act_sram_arb_if #(.DATA_W(DATA_W)) bus ();

    act_sram_arb #(
        .DEPTH (DEPTH),
        .PLANE (PLANE),
        .DATA_W(DATA_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural SRAM: registered read of pre-write data, masked or
    // broadcast write (plane k receives lane 3-k replicated).
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        for (int i = 0; i < 4; i++) mem[i] = DATA_W'(i);
        bus.sram_rdata = '0;
        forever begin
            @(posedge clk);
            if (bus.sram_csb === 1'b0) begin
                bus.sram_rdata <= mem[bus.sram_raddr];
                if (bus.sram_wsb === 1'b0) begin
                    if (bus.sram_msb) begin
                        for (int l = 0; l < 4; l++)
                            if (!bus.sram_wordmask[l])
                                mem[bus.sram_waddr][l*LANE_W +: LANE_W] = bus.sram_wdata[l*LANE_W +: LANE_W];
                    end else begin
                        for (int k = 0; k < 4; k++)
                            for (int l = 0; l < 4; l++)
                                if (!bus.sram_wordmask[l])
                                    mem[int'(bus.sram_waddr) + k*PLANE][l*LANE_W +: LANE_W] =
                                        bus.sram_wdata[(3-k)*LANE_W +: LANE_W];
                    end
                end
            end
        end
    end

    // Monitor: every e_rvalid pops one expectation and checks data and latency.
    always @(negedge clk) begin
        if (bus.e_rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid: got e_rvalid=1 with e_rdata=%h, expected no read in flight (cycle %0d)",
                         bus.e_rdata, cyc);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_cyc = exp_cyc_q.pop_front();
                check("rd_latency", 64'(cyc), 64'(mon_cyc));
                check("rd_data", 64'(bus.e_rdata), 64'(mon_exp));
            end
        end
    end

    // Driver tasks
    task automatic idle();
        bus.l_req   = 1'b0;
        bus.l_bcast = 1'b0;
        bus.l_mask  = 4'h0;
        bus.e_wreq  = 1'b0;
        bus.e_wmask = 4'h0;
        bus.e_rreq  = 1'b0;
        bus.err_clr = 1'b0;
    endtask

    task automatic issue_read(input logic [15:0] a, input logic [DATA_W-1:0] e);
        bus.e_rreq  = 1'b1;
        bus.e_raddr = a;
        exp_q.push_back(e);
        exp_cyc_q.push_back(cyc + 2);
    endtask

    task automatic loader_write(input logic [15:0] a, input logic [DATA_W-1:0] d,
                                input logic [3:0] m, input logic bc);
        bus.l_req   = 1'b1;
        bus.l_addr  = a;
        bus.l_data  = d;
        bus.l_mask  = m;
        bus.l_bcast = bc;
    endtask

    task automatic engine_write(input logic [15:0] a, input logic [DATA_W-1:0] d, input logic [3:0] m);
        bus.e_wreq  = 1'b1;
        bus.e_waddr = a;
        bus.e_wdata = d;
        bus.e_wmask = m;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_csb"}, 64'(bus.sram_csb), 64'd1);
        check({tag, "_wsb"}, 64'(bus.sram_wsb), 64'd1);
        check({tag, "_msb"}, 64'(bus.sram_msb), 64'd1);
        check({tag, "_wordmask"}, 64'(bus.sram_wordmask), 64'hF);
        check({tag, "_waddr"}, 64'(bus.sram_waddr), 64'd0);
        check({tag, "_raddr"}, 64'(bus.sram_raddr), 64'd0);
        check({tag, "_wdata"}, 64'(bus.sram_wdata), 64'd0);
        check({tag, "_rvalid"}, 64'(bus.e_rvalid), 64'd0);
        check({tag, "_rdata"}, 64'(bus.e_rdata), 64'd0);
        check({tag, "_err"}, 64'(bus.err_addr), 64'd0);
        check({tag, "_ptr"}, 64'(bus.arb_ptr), 64'd0);
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before 200000ns");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus
    initial begin
        idle();
        bus.l_addr  = '0;
        bus.l_data  = '0;
        bus.e_waddr = '0;
        bus.e_wdata = '0;
        bus.e_raddr = '0;
`ifdef ACT_SRAM_ARB_RAW_BYPASS_EN
        fwd_exp = 48'hAAA_BBB_000_000;
`else
        fwd_exp = 48'h0;
`endif
        // Reset: requests held high must not be granted
        rst = 1'b1;
        bus.l_req  = 1'b1;
        bus.e_wreq = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_l_gnt", 64'(bus.l_gnt), 64'd0);
        check("rst_e_wgnt", 64'(bus.e_wgnt), 64'd0);
        check_reset_outputs("rst");
        idle();
        @(negedge clk);
        rst = 1'b0;

        // Contention: grants alternate L,E,L,E and each write issues next cycle
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("rr_wsb", 64'(bus.sram_wsb), 64'd0);
                check("rr_waddr", 64'(bus.sram_waddr),
                      ((i - 1) % 2 == 0) ? 64'(100 + i - 1) : 64'(200 + i - 1));
                check("rr_msb", 64'(bus.sram_msb), 64'd1);
            end
            if (i < 4) begin
                loader_write(16'(100 + i), 48'(i), 4'h0, 1'b0);
                engine_write(16'(200 + i), 48'(16 + i), 4'h0);
                #1;
                check("rr_l_gnt", 64'(bus.l_gnt), (i % 2 == 0) ? 64'd1 : 64'd0);
                check("rr_e_wgnt", 64'(bus.e_wgnt), (i % 2 == 0) ? 64'd0 : 64'd1);
            end else begin
                idle();
            end
        end

        // Back-to-back reads of preloaded words 0..3
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            issue_read(16'(i), 48'(i));
        end
        @(negedge clk);
        idle();
        repeat (3) @(negedge clk);
        check("raddr_hold", 64'(bus.sram_raddr), 64'd3);
        check("idle_csb", 64'(bus.sram_csb), 64'd1);

        // Broadcast write one past the last legal base: granted, dropped, error
        @(negedge clk);
        loader_write(16'd47824, 48'h123_456_789_ABC, 4'h0, 1'b1);
        #1;
        check("bc_oor_gnt", 64'(bus.l_gnt), 64'd1);
        @(negedge clk);
        idle();
        check("bc_oor_wsb", 64'(bus.sram_wsb), 64'd1);
        check("bc_oor_err", 64'(bus.err_addr), 64'd1);
        bus.err_clr = 1'b1;
        @(negedge clk);
        idle();
        check("err_clr", 64'(bus.err_addr), 64'd0);

        // Last legal broadcast base
        loader_write(16'd47823, 48'h123_456_789_ABC, 4'h0, 1'b1);
        @(negedge clk);
        idle();
        check("bc_edge_wsb", 64'(bus.sram_wsb), 64'd0);
        check("bc_edge_msb", 64'(bus.sram_msb), 64'd0);
        check("bc_edge_err", 64'(bus.err_addr), 64'd0);
        @(negedge clk);
        issue_read(16'(DEPTH - 1), 48'hABC_ABC_ABC_ABC);

        // Masked write at DEPTH with a simultaneous clear: set wins
        @(negedge clk);
        idle();
        loader_write(16'(DEPTH), 48'h1, 4'h0, 1'b0);
        bus.err_clr = 1'b1;
        @(negedge clk);
        idle();
        check("oor_set_wins", 64'(bus.err_addr), 64'd1);
        check("oor_w_wsb", 64'(bus.sram_wsb), 64'd1);
        bus.err_clr = 1'b1;
        @(negedge clk);
        idle();
        check("err_clr2", 64'(bus.err_addr), 64'd0);

        // Out-of-range read: still answered, with zero data
        issue_read(16'(DEPTH), 48'h0);
        @(negedge clk);
        idle();
        check("oor_r_err", 64'(bus.err_addr), 64'd1);
        bus.err_clr = 1'b1;
        @(negedge clk);
        idle();
        repeat (2) @(negedge clk);

        // Broadcast write at 10, then read back all four planes
        loader_write(16'd10, 48'h001_002_003_004, 4'h0, 1'b1);
        #1;
        check("bc_gnt", 64'(bus.l_gnt), 64'd1);
        @(negedge clk);
        idle();
        check("bc_msb", 64'(bus.sram_msb), 64'd0);
        check("bc_wsb", 64'(bus.sram_wsb), 64'd0);
        check("bc_waddr", 64'(bus.sram_waddr), 64'd10);
        @(negedge clk);
        issue_read(16'd10, 48'h001_001_001_001);
        @(negedge clk);
        issue_read(16'd794, 48'h002_002_002_002);
        @(negedge clk);
        issue_read(16'd1578, 48'h003_003_003_003);
        @(negedge clk);
        issue_read(16'd2362, 48'h004_004_004_004);
        @(negedge clk);
        idle();
        repeat (2) @(negedge clk);

        // Masked engine write plus same-address read in one cycle
        engine_write(16'd5, 48'hAAA_BBB_CCC_DDD, 4'b0011);
        issue_read(16'd5, fwd_exp);
        #1;
        check("raw_e_wgnt", 64'(bus.e_wgnt), 64'd1);
        @(negedge clk);
        idle();
        check("raw_csb", 64'(bus.sram_csb), 64'd0);
        check("raw_wsb", 64'(bus.sram_wsb), 64'd0);
        check("raw_msb", 64'(bus.sram_msb), 64'd1);
        check("raw_mask", 64'(bus.sram_wordmask), 64'h3);
        check("raw_raddr", 64'(bus.sram_raddr), 64'd5);
        @(negedge clk);
        issue_read(16'd5, 48'hAAA_BBB_000_000);
        @(negedge clk);
        idle();

        // Broadcast write plus same-address read: never forwarded
        loader_write(16'd20, 48'h111_222_333_444, 4'h0, 1'b1);
        issue_read(16'd20, 48'h0);
        @(negedge clk);
        idle();
        @(negedge clk);
        issue_read(16'd20, 48'h111_111_111_111);
        @(negedge clk);
        idle();
        repeat (2) @(negedge clk);

        // Lone requester keeps pointer; contention moves it
        engine_write(16'd300, 48'h5, 4'h0);
        #1;
        check("lone_e_wgnt", 64'(bus.e_wgnt), 64'd1);
        @(negedge clk);
        idle();
        check("lone_ptr", 64'(bus.arb_ptr), 64'd0);
        loader_write(16'd301, 48'h6, 4'h0, 1'b0);
        engine_write(16'd302, 48'h7, 4'h0);
        #1;
        check("pair_l_gnt", 64'(bus.l_gnt), 64'd1);
        @(negedge clk);
        idle();
        check("pair_ptr", 64'(bus.arb_ptr), 64'd1);

        // Reset in the cycle after a read and write are accepted
        issue_read(16'd1, 48'h0);
        exp_q.delete();
        exp_cyc_q.delete();
        loader_write(16'd303, 48'h8, 4'h0, 1'b0);
        @(negedge clk);
        idle();
        check("pre_rst_csb", 64'(bus.sram_csb), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("flight");
        @(negedge clk);
        check("flight_rvalid2", 64'(bus.e_rvalid), 64'd0);
        rst = 1'b0;
        loader_write(16'd304, 48'h9, 4'h0, 1'b0);
        engine_write(16'd305, 48'hA, 4'h0);
        #1;
        check("post_rst_l_gnt", 64'(bus.l_gnt), 64'd1);
        check("post_rst_e_wgnt", 64'(bus.e_wgnt), 64'd0);
        @(negedge clk);
        idle();
        repeat (4) @(negedge clk);

        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
